truth_table_sweeper: RTL

//   Sequential stimulus/check stage around a combinational Boolean function block (A,B,C -> F).
//   On start, drives all 2**N_IN input combinations in ascending binary order on abc_out.

---
 rtl/truth_table_sweeper.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper
// Stimulus/check stage for a small combinational Boolean block. After a start
// request it walks abc_out through every input combination in ascending order.
// Each vector is held for SETTLE cycles and then sampled on one more cycle. The
// sampled F is compared against the EXPECTED truth table. When the sweep ends,
// the stage reports the mismatch count, the first failing index and pass/fail.

module truth_table_sweeper #(
    parameter int unsigned          N_IN     = 3,
    parameter logic [2**N_IN-1:0]   EXPECTED = 8'hE8,
    parameter int unsigned          SETTLE   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              f_in,
    output logic [N_IN-1:0]   abc_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic              fail_valid,
    output logic [N_IN-1:0]   first_fail_idx
);

    // Settle counter width. SETTLE = 0 still needs a 1-bit counter that
    // stays at zero.
    localparam int unsigned     WCW      = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam int unsigned     EW       = N_IN + 1;
    localparam logic [WCW-1:0]  SETTLE_W = WCW'(SETTLE);
    localparam logic [WCW-1:0]  WC_ZERO  = WCW'(1'b0);
    localparam logic [WCW-1:0]  WC_ONE   = WCW'(1'b1);
    localparam logic [N_IN-1:0] IDX_ZERO = N_IN'(1'b0);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1'b1);
    localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};
    localparam logic [EW-1:0]   ERR_ZERO = EW'(1'b0);
    localparam logic [EW-1:0]   ERR_ONE  = EW'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [EW-1:0]   err_count_q, err_count_d;
    logic            fail_valid_q, fail_valid_d;
    logic [N_IN-1:0] first_fail_idx_q, first_fail_idx_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic [N_IN-1:0] abc_q, abc_d;

    logic            sample_s;
    logic            last_vec_s;
    logic            mismatch_s;

    // Look up the required F for one input vector in the truth table.
    function automatic logic expected_bit(input logic [N_IN-1:0] vec);
        return EXPECTED[vec];
    endfunction

    // The sample cycle is the last cycle a vector is held. The terminal
    // vector is recognised by its index, so idx never has to wrap.
    assign sample_s   = (state_q == ST_RUN) && (wait_cnt_q == SETTLE_W);
    assign last_vec_s = (idx_q == LAST_IDX);
    assign mismatch_s = sample_s && (f_in != expected_bit(idx_q));

    // State register; reset aborts any sweep immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE waits for start, RUN ends on the terminal sample,
    // DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sample_s && last_vec_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/datapath next values: sweep bookkeeping and the registered outputs.
    always_comb begin
        idx_d            = idx_q;
        wait_cnt_d       = wait_cnt_q;
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_idx_d = first_fail_idx_q;
        pass_d           = pass_q;
        done_d           = 1'b0;
        busy_d           = 1'b0;
        abc_d            = IDX_ZERO;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // An accepted start clears the previous results.
                    idx_d            = IDX_ZERO;
                    wait_cnt_d       = WC_ZERO;
                    err_count_d      = ERR_ZERO;
                    fail_valid_d     = 1'b0;
                    first_fail_idx_d = IDX_ZERO;
                    pass_d           = 1'b0;
                    busy_d           = 1'b1;
                    abc_d            = IDX_ZERO;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (sample_s) begin
                    if (mismatch_s) begin
                        err_count_d = err_count_q + ERR_ONE;
                        if (!fail_valid_q) begin
                            first_fail_idx_d = idx_q;
                            fail_valid_d     = 1'b1;
                        end else begin
                            first_fail_idx_d = first_fail_idx_q;
                        end
                    end else begin
                        err_count_d = err_count_q;
                    end
                    wait_cnt_d = WC_ZERO;
                    if (last_vec_s) begin
                        // pass uses the count that already includes the final compare.
                        done_d = 1'b1;
                        pass_d = (err_count_d == ERR_ZERO);
                    end else begin
                        idx_d  = idx_q + IDX_ONE;
                        busy_d = 1'b1;
                        abc_d  = idx_q + IDX_ONE;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WC_ONE;
                    busy_d     = 1'b1;
                    abc_d      = idx_q;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset clears everything, so no done pulse follows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q            <= IDX_ZERO;
            wait_cnt_q       <= WC_ZERO;
            err_count_q      <= ERR_ZERO;
            fail_valid_q     <= 1'b0;
            first_fail_idx_q <= IDX_ZERO;
            pass_q           <= 1'b0;
            done_q           <= 1'b0;
            busy_q           <= 1'b0;
            abc_q            <= IDX_ZERO;
        end else begin
            idx_q            <= idx_d;
            wait_cnt_q       <= wait_cnt_d;
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_idx_q <= first_fail_idx_d;
            pass_q           <= pass_d;
            done_q           <= done_d;
            busy_q           <= busy_d;
            abc_q            <= abc_d;
        end
    end

    assign abc_out        = abc_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_idx_q;

endmodule
